// File: rtl/alu_arbiter_if.sv
// Requester, response and ALU-side signal bundle for alu_arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the ALU.
interface alu_arbiter_if #(
    parameter int W = 8
);
    logic         req0_valid;
    logic         req1_valid;
    logic         req0_ready;
    logic         req1_ready;
    logic [2:0]   req0_op;
    logic [2:0]   req1_op;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         rsp0_valid;
    logic         rsp1_valid;
    logic         rsp0_ready;
    logic         rsp1_ready;
    logic [W-1:0] rsp_result;
    logic         rsp_zero;
    logic         rsp_err;
    logic [W-1:0] alu_data1;
    logic [W-1:0] alu_data2;
    logic [2:0]   alu_operation;
    logic [W-1:0] alu_result;
    logic         alu_zero;

    modport slave (
        input  req0_valid, req1_valid, req0_op, req1_op,
        input  req0_a, req0_b, req1_a, req1_b,
        input  rsp0_ready, rsp1_ready, alu_result, alu_zero,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        output rsp_result, rsp_zero, rsp_err,
        output alu_data1, alu_data2, alu_operation
    );

    modport master (
        output req0_valid, req1_valid, req0_op, req1_op,
        output req0_a, req0_b, req1_a, req1_b,
        output rsp0_ready, rsp1_ready, alu_result, alu_zero,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
        input  rsp_result, rsp_zero, rsp_err,
        input  alu_data1, alu_data2, alu_operation
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared multi-cycle ALU: round-robin on ties,
// one operation in flight, response held on the shared payload until its handshake.
module alu_arbiter #(
    parameter int W        = 8,
    parameter int ALU_WAIT = 2
) (
    input  logic         CLK,
    input  logic         RESET,
    alu_arbiter_if.slave bus,
    output logic         busy
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [3:0] WAIT_LOAD = 4'(ALU_WAIT);

    logic [1:0]   r_state;
    logic [3:0]   r_cnt;
    logic         r_last_grant;
    logic [2:0]   r_op;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic [W-1:0] r_rsp_result;
    logic         r_rsp_zero;
    logic         r_rsp_err;

    logic         w_any;
    logic         w_sel;
    logic         w_accept;
    logic         w_handshake;
    logic [2:0]   w_op;
    logic [W-1:0] w_a;
    logic [W-1:0] w_b;

    // Arbitration, acceptance and response handshake decode.
    always_comb begin
        w_any = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            w_sel = ~r_last_grant;
        end else begin
            w_sel = bus.req1_valid;
        end
        w_accept = (r_state == ST_IDLE) && !RESET && w_any;
        if (r_last_grant) begin
            w_handshake = (r_state == ST_RESP) && bus.rsp1_ready;
        end else begin
            w_handshake = (r_state == ST_RESP) && bus.rsp0_ready;
        end
        if (w_sel) begin
            w_op = bus.req1_op;
            w_a  = bus.req1_a;
            w_b  = bus.req1_b;
        end else begin
            w_op = bus.req0_op;
            w_a  = bus.req0_a;
            w_b  = bus.req0_b;
        end
    end

    // Status outputs are gated by RESET so nothing looks live while reset is held.
    assign bus.req0_ready    = w_accept && !w_sel;
    assign bus.req1_ready    = w_accept && w_sel;
    assign bus.rsp0_valid    = (r_state == ST_RESP) && !r_last_grant && !RESET;
    assign bus.rsp1_valid    = (r_state == ST_RESP) && r_last_grant && !RESET;
    assign busy              = (r_state != ST_IDLE) && !RESET;
    assign bus.rsp_result    = r_rsp_result;
    assign bus.rsp_zero      = r_rsp_zero;
    assign bus.rsp_err       = r_rsp_err;
    assign bus.alu_data1     = r_a;
    assign bus.alu_data2     = r_b;
    assign bus.alu_operation = r_op;

    // Main FSM: latch on accept, wait out the ALU, hold the response until consumed.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 4'd0;
            r_last_grant <= 1'b1;
            r_op         <= 3'd0;
            r_a          <= {W{1'b0}};
            r_b          <= {W{1'b0}};
            r_rsp_result <= {W{1'b0}};
            r_rsp_zero   <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op         <= w_op;
                        r_a          <= w_a;
                        r_b          <= w_b;
                        r_last_grant <= w_sel;
                        r_cnt        <= WAIT_LOAD;
                        if (w_op[2]) begin
                            // Reserved op: answer immediately with an error, ALU untouched.
                            r_state      <= ST_RESP;
                            r_rsp_result <= {W{1'b0}};
                            r_rsp_zero   <= 1'b0;
                            r_rsp_err    <= 1'b1;
                        end else begin
                            r_state <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_rsp_result <= bus.alu_result;
                        r_rsp_zero   <= bus.alu_zero;
                        r_rsp_err    <= 1'b0;
                        r_state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (w_handshake) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a randomized run
// against a grant/latency/payload reference; the bench also plays the ALU.
module tb_alu_arbiter;
    localparam int W        = 8;
    localparam int ALU_WAIT = 2;

    logic CLK = 1'b0;
    logic RESET;
    logic busy;
    logic zflip = 1'b0;
    logic model_last;
    int   n_pass  = 0;
    int   n_total = 0;

    alu_arbiter_if #(.W(W)) bus ();

    alu_arbiter #(.W(W), .ALU_WAIT(ALU_WAIT)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 CLK = ~CLK;

    function automatic logic [W-1:0] alu_fn(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op[1:0])
            2'd0:    return a & b;
            2'd1:    return a + b;
            2'd2:    return a - b;
            default: return a | b;
        endcase
    endfunction

    // Bench-side ALU; zflip lets the zero flag disagree with the result to prove pass-through.
    assign bus.alu_result = alu_fn(bus.alu_operation, bus.alu_data1, bus.alu_data2);
    assign bus.alu_zero   = (alu_fn(bus.alu_operation, bus.alu_data1, bus.alu_data2) == {W{1'b0}}) ^ zflip;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v0, input logic v1,
                         input logic [2:0] o0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                         input logic [2:0] o1, input logic [W-1:0] a1, input logic [W-1:0] b1);
        bus.req0_valid = v0; bus.req0_op = o0; bus.req0_a = a0; bus.req0_b = b0;
        bus.req1_valid = v1; bus.req1_op = o1; bus.req1_a = a1; bus.req1_b = b1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
    endtask

    // Edges from the acceptance edge until rspN_valid is seen; -1 if it never comes.
    task automatic wait_rsp(input int n, output int lat);
        lat = -1;
        for (int k = 0; k <= 40; k++) begin
            if ((n == 0 ? bus.rsp0_valid : bus.rsp1_valid) === 1'b1) begin
                lat = k;
                break;
            end
            tick();
        end
    endtask

    task automatic finish_rsp(input int n);
        if (n == 0) bus.rsp0_ready = 1'b1; else bus.rsp1_ready = 1'b1;
        tick();
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        drive(1'b1, 1'b1, 3'd1, 8'h11, 8'h22, 3'd2, 8'h33, 8'h44);
        tick();
        tick();
        n_total++; if (bus.req0_ready !== 1'b0) $display("FAIL rst_ready0: got %b want 0", bus.req0_ready); else n_pass++;
        n_total++; if (bus.req1_ready !== 1'b0) $display("FAIL rst_ready1: got %b want 0", bus.req1_ready); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
        n_total++; if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b00) $display("FAIL rst_rsp_valid: got %b want 00", {bus.rsp0_valid, bus.rsp1_valid}); else n_pass++;
        n_total++; if ({bus.rsp_result, bus.rsp_zero, bus.rsp_err} !== 10'd0) $display("FAIL rst_payload: got %h want 0", {bus.rsp_result, bus.rsp_zero, bus.rsp_err}); else n_pass++;
        n_total++; if ({bus.alu_operation, bus.alu_data1, bus.alu_data2} !== 19'd0) $display("FAIL rst_alu_drive: got %h want 0", {bus.alu_operation, bus.alu_data1, bus.alu_data2}); else n_pass++;
        drive(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 3'd0, 8'h00, 8'h00);
        RESET = 1'b0;
        tick();
        n_total++; if (busy !== 1'b0) $display("FAIL rst_post_busy: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_single_add();
        int lat;
        drive(1'b1, 1'b0, 3'b001, 8'h05, 8'h03, 3'd0, 8'h00, 8'h00);
        #1;
        n_total++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) $display("FAIL add_ready: got %b want 10", {bus.req0_ready, bus.req1_ready}); else n_pass++;
        tick();
        bus.req0_valid = 1'b0;
        n_total++; if (busy !== 1'b1) $display("FAIL add_busy: got %b want 1", busy); else n_pass++;
        n_total++; if ({bus.alu_operation, bus.alu_data1, bus.alu_data2} !== {3'b001, 8'h05, 8'h03}) $display("FAIL add_alu_drive: got %h want %h", {bus.alu_operation, bus.alu_data1, bus.alu_data2}, {3'b001, 8'h05, 8'h03}); else n_pass++;
        wait_rsp(0, lat);
        n_total++; if (lat !== ALU_WAIT) $display("FAIL add_latency: got %0d want %0d", lat, ALU_WAIT); else n_pass++;
        n_total++; if ({bus.rsp_result, bus.rsp_zero, bus.rsp_err} !== {8'h08, 1'b0, 1'b0}) $display("FAIL add_payload: got %h want %h", {bus.rsp_result, bus.rsp_zero, bus.rsp_err}, {8'h08, 1'b0, 1'b0}); else n_pass++;
        n_total++; if (bus.rsp1_valid !== 1'b0) $display("FAIL add_rsp1_quiet: got %b want 0", bus.rsp1_valid); else n_pass++;
        finish_rsp(0);
        n_total++; if ({busy, bus.rsp0_valid} !== 2'b00) $display("FAIL add_done: got %b want 00", {busy, bus.rsp0_valid}); else n_pass++;
    endtask

    task automatic test_tie();
        int lat;
        int exp_n;
        logic [W-1:0] exp_res;
        do_reset();
        drive(1'b1, 1'b1, 3'b011, 8'h30, 8'h0C, 3'b010, 8'h50, 8'h10);
        for (int i = 0; i < 4; i++) begin
            exp_n = i % 2;
            #1;
            n_total++; if ({bus.req0_ready, bus.req1_ready} !== ((exp_n == 0) ? 2'b10 : 2'b01)) $display("FAIL tie_grant%0d: got %b want grant %0d", i, {bus.req0_ready, bus.req1_ready}, exp_n); else n_pass++;
            tick();
            wait_rsp(exp_n, lat);
            exp_res = (exp_n == 0) ? alu_fn(3'b011, 8'h30, 8'h0C) : alu_fn(3'b010, 8'h50, 8'h10);
            n_total++; if (lat !== ALU_WAIT) $display("FAIL tie_latency%0d: got %0d want %0d", i, lat, ALU_WAIT); else n_pass++;
            n_total++; if (bus.rsp_result !== exp_res) $display("FAIL tie_result%0d: got %h want %h", i, bus.rsp_result, exp_res); else n_pass++;
            finish_rsp(exp_n);
        end
        drive(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 3'd0, 8'h00, 8'h00);
        tick();
    endtask

    task automatic test_zero_flag();
        int lat;
        drive(1'b0, 1'b1, 3'd0, 8'h00, 8'h00, 3'b001, 8'hFF, 8'h01);
        #1;
        n_total++; if ({bus.req0_ready, bus.req1_ready} !== 2'b01) $display("FAIL zero_ready: got %b want 01", {bus.req0_ready, bus.req1_ready}); else n_pass++;
        tick();
        bus.req1_valid = 1'b0;
        wait_rsp(1, lat);
        n_total++; if (lat !== ALU_WAIT) $display("FAIL zero_latency: got %0d want %0d", lat, ALU_WAIT); else n_pass++;
        n_total++; if ({bus.rsp_result, bus.rsp_zero, bus.rsp_err} !== {8'h00, 1'b1, 1'b0}) $display("FAIL zero_payload: got %h want %h", {bus.rsp_result, bus.rsp_zero, bus.rsp_err}, {8'h00, 1'b1, 1'b0}); else n_pass++;
        finish_rsp(1);
    endtask

    task automatic test_backpressure();
        int lat;
        int bad = 0;
        drive(1'b1, 1'b0, 3'b001, 8'h12, 8'h34, 3'b000, 8'h0F, 8'hF0);
        #1;
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1;
        wait_rsp(0, lat);
        n_total++; if (lat !== ALU_WAIT) $display("FAIL bp_latency: got %0d want %0d", lat, ALU_WAIT); else n_pass++;
        bus.rsp1_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if ({bus.rsp0_valid, bus.rsp1_valid, bus.req1_ready, busy, bus.rsp_result, bus.rsp_err} !== {4'b1001, 8'h46, 1'b0}) bad++;
        end
        n_total++; if (bad != 0) $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); else n_pass++;
        bus.rsp1_ready = 1'b0;
        finish_rsp(0);
        n_total++; if (busy !== 1'b0) $display("FAIL bp_release_idle: got busy %b want 0", busy); else n_pass++;
        n_total++; if (bus.req1_ready !== 1'b1) $display("FAIL bp_idle_ready1: got %b want 1", bus.req1_ready); else n_pass++;
        bus.req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_reserved();
        int lat;
        drive(1'b1, 1'b0, 3'b101, 8'hA5, 8'h5A, 3'd0, 8'h00, 8'h00);
        #1;
        tick();
        bus.req0_valid = 1'b0;
        wait_rsp(0, lat);
        n_total++; if (lat !== 0) $display("FAIL rsv_latency: got %0d want 0", lat); else n_pass++;
        n_total++; if ({bus.rsp_result, bus.rsp_zero, bus.rsp_err} !== {8'h00, 1'b0, 1'b1}) $display("FAIL rsv_payload: got %h want %h", {bus.rsp_result, bus.rsp_zero, bus.rsp_err}, {8'h00, 1'b0, 1'b1}); else n_pass++;
        n_total++; if (bus.alu_operation !== 3'b101) $display("FAIL rsv_alu_op: got %b want 101", bus.alu_operation); else n_pass++;
        finish_rsp(0);
    endtask

    task automatic test_reset_mid_op();
        int lat;
        int seen = 0;
        drive(1'b0, 1'b1, 3'd0, 8'h00, 8'h00, 3'b010, 8'h09, 8'h04);
        #1;
        tick();
        bus.req1_valid = 1'b0;
        tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        n_total++; if ({busy, bus.alu_data1} !== {1'b0, 8'h00}) $display("FAIL mid_reset_busy: got %h want 0", {busy, bus.alu_data1}); else n_pass++;
        for (int i = 0; i < ALU_WAIT + 4; i++) begin
            if (bus.rsp0_valid === 1'b1 || bus.rsp1_valid === 1'b1) seen++;
            tick();
        end
        n_total++; if (seen != 0) $display("FAIL mid_reset_no_rsp: got %0d rsp cycles want 0", seen); else n_pass++;
        // Reset arriving together with a response handshake must still clear the payload.
        drive(1'b1, 1'b0, 3'b110, 8'h01, 8'h02, 3'd0, 8'h00, 8'h00);
        #1;
        tick();
        bus.req0_valid = 1'b0;
        wait_rsp(0, lat);
        bus.rsp0_ready = 1'b1;
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        bus.rsp0_ready = 1'b0;
        n_total++; if ({busy, bus.rsp0_valid, bus.rsp_err} !== 3'b000) $display("FAIL rst_over_handshake: got %b want 000", {busy, bus.rsp0_valid, bus.rsp_err}); else n_pass++;
        tick();
    endtask

    task automatic test_random();
        logic v0, v1, win, rsv;
        logic [2:0]   o0, o1, op;
        logic [W-1:0] a0, b0, a1, b1, ea, eb, exp_res;
        logic         exp_zero;
        int lat, hold;
        do_reset();
        model_last = 1'b1;
        for (int it = 0; it < 60; it++) begin
            v0 = 1'($urandom_range(0, 1)); v1 = 1'($urandom_range(0, 1));
            o0 = 3'($urandom); o1 = 3'($urandom);
            a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
            zflip = 1'($urandom_range(0, 1));
            drive(v0, v1, o0, a0, b0, o1, a1, b1);
            #1;
            if (!v0 && !v1) begin
                n_total++; if ({bus.req0_ready, bus.req1_ready, busy} !== 3'b000) $display("FAIL rnd_idle%0d: got %b want 000", it, {bus.req0_ready, bus.req1_ready, busy}); else n_pass++;
                tick();
                continue;
            end
            // Reference: a lone requester wins; on a tie the one not served last time wins.
            win = (v0 && v1) ? !model_last : v1;
            n_total++; if ({bus.req0_ready, bus.req1_ready} !== {!win, win}) $display("FAIL rnd_grant%0d: got %b want %b", it, {bus.req0_ready, bus.req1_ready}, {!win, win}); else n_pass++;
            tick();
            model_last = win;
            bus.req0_valid = 1'b0;
            bus.req1_valid = 1'b0;
            op = win ? o1 : o0; ea = win ? a1 : a0; eb = win ? b1 : b0;
            rsv = op[2];
            exp_res  = rsv ? {W{1'b0}} : alu_fn(op, ea, eb);
            exp_zero = rsv ? 1'b0 : ((exp_res == {W{1'b0}}) ^ zflip);
            n_total++; if ({bus.alu_operation, bus.alu_data1, bus.alu_data2} !== {op, ea, eb}) $display("FAIL rnd_alu_drive%0d: got %h want %h", it, {bus.alu_operation, bus.alu_data1, bus.alu_data2}, {op, ea, eb}); else n_pass++;
            wait_rsp(int'(win), lat);
            n_total++; if (lat !== (rsv ? 0 : ALU_WAIT)) $display("FAIL rnd_latency%0d: got %0d want %0d", it, lat, rsv ? 0 : ALU_WAIT); else n_pass++;
            hold = $urandom_range(0, 3);
            if (win) bus.rsp0_ready = 1'($urandom_range(0, 1)); else bus.rsp1_ready = 1'($urandom_range(0, 1));
            repeat (hold) tick();
            n_total++; if ({bus.rsp0_valid, bus.rsp1_valid} !== {!win, win}) $display("FAIL rnd_rsp_valid%0d: got %b want %b", it, {bus.rsp0_valid, bus.rsp1_valid}, {!win, win}); else n_pass++;
            n_total++; if ({bus.rsp_result, bus.rsp_zero, bus.rsp_err} !== {exp_res, exp_zero, rsv}) $display("FAIL rnd_payload%0d: got %h want %h", it, {bus.rsp_result, bus.rsp_zero, bus.rsp_err}, {exp_res, exp_zero, rsv}); else n_pass++;
            finish_rsp(int'(win));
            n_total++; if (busy !== 1'b0) $display("FAIL rnd_done%0d: got busy %b want 0", it, busy); else n_pass++;
        end
        zflip = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_add();
        test_tie();
        test_zero_flag();
        test_backpressure();
        test_reserved();
        test_reset_mid_op();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
